// File: rtl/level_loader.sv
`default_nettype none
// ============================================================================
// Module   : level_loader
// Brief    : Streams one level's 40 scene descriptors from the level ROM into
//            a shadow buffer and commits them to the active tables atomically
//            at the next frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module level_loader #(
    parameter int NUM_LEVELS   = 4,
    parameter int LEVEL_STRIDE = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_req,
    input  logic [1:0]  level,
    input  logic        frame_start,
    output logic [7:0]  rom_addr,
    input  logic [28:0] rom_data,
    output logic [28:0] info_ground [16],
    output logic [28:0] info_fence  [16],
    output logic [9:0]  info_exit   [2],
    output logic [20:0] info_spince [6],
    output logic        busy,
    output logic        load_done,
    output logic [1:0]  active_level
);

    localparam int         c_LVL_W    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int         c_WORDS    = 40;
    localparam logic [5:0] c_LAST_OFF = 6'd39;
    localparam logic [7:0] c_STRIDE   = 8'(LEVEL_STRIDE);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_WAIT  = 2'd3;

    logic [1:0]         r_state;
    logic [c_LVL_W-1:0] r_level;
    logic [5:0]         r_off;
    logic [28:0]        r_shadow [c_WORDS];

    logic [c_LVL_W-1:0] w_lvl_in;
    logic [7:0]         w_base;
    logic               w_accept;

    assign w_lvl_in = level[c_LVL_W-1:0];
    assign w_base   = 8'(w_lvl_in) * c_STRIDE;
    // A request restarts the load from IDLE or WAIT_FRAME and beats a same-cycle commit.
    assign w_accept = load_req && ((r_state == c_ST_IDLE) || (r_state == c_ST_WAIT));
    assign busy     = (r_state != c_ST_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= c_ST_IDLE;
            r_level      <= '0;
            r_off        <= '0;
            rom_addr     <= '0;
            load_done    <= 1'b0;
            active_level <= '0;
            for (int i = 0; i < 16; i++) begin
                info_ground[i] <= '0;
                info_fence[i]  <= '0;
            end
            for (int i = 0; i < 2; i++) info_exit[i] <= '0;
            for (int i = 0; i < 6; i++) info_spince[i] <= '0;
        end else begin
            load_done <= 1'b0;
            if (w_accept) begin
                r_state  <= c_ST_FETCH;
                r_level  <= w_lvl_in;
                r_off    <= '0;
                rom_addr <= w_base;
            end else begin
                case (r_state)
                    c_ST_FETCH: begin
                        if (r_off == c_LAST_OFF) begin
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_off    <= r_off + 6'd1;
                            rom_addr <= rom_addr + 8'd1;
                        end
                    end
                    c_ST_DRAIN: r_state <= c_ST_WAIT;
                    c_ST_WAIT: begin
                        if (frame_start) begin
                            r_state      <= c_ST_IDLE;
                            load_done    <= 1'b1;
                            active_level <= 2'(r_level);
                            for (int i = 0; i < 16; i++) begin
                                info_ground[i] <= r_shadow[i];
                                info_fence[i]  <= r_shadow[16 + i];
                            end
                            for (int i = 0; i < 2; i++) info_exit[i] <= r_shadow[32 + i][9:0];
                            for (int i = 0; i < 6; i++) info_spince[i] <= r_shadow[34 + i][20:0];
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // ROM data lags the address by one cycle, so each write lands one slot behind r_off.
    always_ff @(posedge Clk) begin
        if ((r_state == c_ST_FETCH) && (r_off != 6'd0)) begin
            r_shadow[r_off - 6'd1] <= rom_data;
        end else if (r_state == c_ST_DRAIN) begin
            r_shadow[c_LAST_OFF] <= rom_data;
        end
    end

endmodule
`default_nettype wire
